// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D-cache memory arbiter: state encoding,
// owner codes and default line geometry.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int LINE_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_e;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_I    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

    // last_grant encoding: which requester held the port most recently
    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    function automatic logic [1:0] state_to_owner(input arb_state_e s);
        logic [1:0] o;
        case (s)
            GRANT_I: o = OWN_I;
            GRANT_D: o = OWN_D;
            IDLE:    o = OWN_NONE;
            default: o = OWN_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Arbitration decision between the I and D requesters; purely combinational
// so it can be exercised exhaustively on its own.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic       req_i,
    input  logic       req_d,
    input  logic       last_grant,
    output logic [1:0] winner
);

    // Fixed priority favours D on a tie; round-robin favours whoever did not go last.
    always_comb begin
        winner = OWN_NONE;
        case ({req_i, req_d})
            2'b10: winner = OWN_I;
            2'b01: winner = OWN_D;
            2'b11: begin
                if ((RR_EN != 0) && (last_grant == LAST_D)) begin
                    winner = OWN_I;
                end else begin
                    winner = OWN_D;
                end
            end
            default: winner = OWN_NONE;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache, granting
// one whole transaction at a time and holding it until mem_ready.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [LINE_W-1:0] i_mem_wdata,
    output logic [LINE_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,

    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [LINE_W-1:0] d_mem_wdata,
    output logic [LINE_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,

    output logic [1:0]        owner
);

    arb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              req_i_s;
    logic              req_d_s;
    logic [1:0]        winner_s;

    assign req_i_s = i_mem_read | i_mem_write;
    assign req_d_s = d_mem_read | d_mem_write;

    mem_arb_pick #(
        .RR_EN (RR_EN)
    ) u_pick (
        .req_i      (req_i_s),
        .req_d      (req_d_s),
        .last_grant (last_grant_q),
        .winner     (winner_s)
    );

    // State register and captured memory-side request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= LAST_I;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Next-state: capture the winner in IDLE, release on mem_ready.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            IDLE: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                if (winner_s == OWN_I) begin
                    state_d      = GRANT_I;
                    last_grant_d = LAST_I;
                    mem_read_d   = i_mem_read;
                    mem_write_d  = i_mem_write;
                    mem_addr_d   = i_mem_addr;
                    mem_wdata_d  = i_mem_wdata;
                end else if (winner_s == OWN_D) begin
                    state_d      = GRANT_D;
                    last_grant_d = LAST_D;
                    mem_read_d   = d_mem_read;
                    mem_write_d  = d_mem_write;
                    mem_addr_d   = d_mem_addr;
                    mem_wdata_d  = d_mem_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT_I, GRANT_D: begin
                // Address and data deliberately keep their last values after completion.
                if (mem_ready) begin
                    state_d     = IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // Outputs: registered strobes, combinational return path and owner decode.
    always_comb begin
        mem_read    = mem_read_q;
        mem_write   = mem_write_q;
        mem_addr    = mem_addr_q;
        mem_wdata   = mem_wdata_q;
        i_mem_rdata = mem_rdata;
        d_mem_rdata = mem_rdata;
        i_mem_ready = mem_ready & (state_q == GRANT_I);
        d_mem_ready = mem_ready & (state_q == GRANT_D);
        owner       = state_to_owner(state_q);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one round-robin and one fixed-priority
// instance, expected grants queued at stimulus time and popped on each grant.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct packed {
        logic [1:0]   own;
        logic         rd;
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // index 0: RR_EN=1 instance, index 1: RR_EN=0 instance
    logic         i_rd[2], i_wr[2], d_rd[2], d_wr[2];
    logic [27:0]  i_ad[2], d_ad[2], m_ad[2];
    logic [127:0] i_wd[2], d_wd[2], m_wd[2];
    logic [127:0] i_rdat[2], d_rdat[2], m_rdat[2];
    logic         i_rdy[2], d_rdy[2], m_rd[2], m_wr[2], m_rdy[2];
    logic [1:0]   own[2];

    mem_arbiter #(.ADDR_W(28), .LINE_W(128), .RR_EN(1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .i_mem_read(i_rd[0]), .i_mem_write(i_wr[0]), .i_mem_addr(i_ad[0]), .i_mem_wdata(i_wd[0]),
        .i_mem_rdata(i_rdat[0]), .i_mem_ready(i_rdy[0]),
        .d_mem_read(d_rd[0]), .d_mem_write(d_wr[0]), .d_mem_addr(d_ad[0]), .d_mem_wdata(d_wd[0]),
        .d_mem_rdata(d_rdat[0]), .d_mem_ready(d_rdy[0]),
        .mem_read(m_rd[0]), .mem_write(m_wr[0]), .mem_addr(m_ad[0]), .mem_wdata(m_wd[0]),
        .mem_rdata(m_rdat[0]), .mem_ready(m_rdy[0]), .owner(own[0])
    );

    mem_arbiter #(.ADDR_W(28), .LINE_W(128), .RR_EN(0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .i_mem_read(i_rd[1]), .i_mem_write(i_wr[1]), .i_mem_addr(i_ad[1]), .i_mem_wdata(i_wd[1]),
        .i_mem_rdata(i_rdat[1]), .i_mem_ready(i_rdy[1]),
        .d_mem_read(d_rd[1]), .d_mem_write(d_wr[1]), .d_mem_addr(d_ad[1]), .d_mem_wdata(d_wd[1]),
        .d_mem_rdata(d_rdat[1]), .d_mem_ready(d_rdy[1]),
        .mem_read(m_rd[1]), .mem_write(m_wr[1]), .mem_addr(m_ad[1]), .mem_wdata(m_wd[1]),
        .mem_rdata(m_rdat[1]), .mem_ready(m_rdy[1]), .owner(own[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    txn_t       exp_q0[$];
    txn_t       exp_q1[$];
    txn_t       last_exp[2];
    logic [1:0] prev_own[2] = '{2'b00, 2'b00};

    task automatic expect_txn(input int k, input logic [1:0] o, input logic rd, input logic wr,
                              input logic [27:0] a, input logic [127:0] w);
        txn_t t;
        t = '{own: o, rd: rd, wr: wr, addr: a, wdata: w};
        if (k == 0) exp_q0.push_back(t);
        else        exp_q1.push_back(t);
    endtask

    // Scoreboard: each new grant must match the oldest queued expectation.
    always @(negedge clk) begin : mon
        txn_t e;
        for (int k = 0; k < 2; k++) begin
            if (own[k] != OWN_NONE && prev_own[k] == OWN_NONE) begin
                if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
                    check("grant_unexpected", {126'd0, own[k]}, 128'd0);
                end else begin
                    if (k == 0) e = exp_q0.pop_front();
                    else        e = exp_q1.pop_front();
                    last_exp[k] <= e;
                    check("grant_owner", {126'd0, own[k]}, {126'd0, e.own});
                    check("grant_read",  {127'd0, m_rd[k]}, {127'd0, e.rd});
                    check("grant_write", {127'd0, m_wr[k]}, {127'd0, e.wr});
                    check("grant_addr",  {100'd0, m_ad[k]}, {100'd0, e.addr});
                    check("grant_wdata", m_wd[k], e.wdata);
                    check("grant_rd_and_wr", {127'd0, m_rd[k] & m_wr[k]}, 128'd0);
                end
            end
            prev_own[k] <= own[k];
        end
    end

    task automatic set_req(input int k, input logic is_d, input logic rd, input logic wr,
                           input logic [27:0] a, input logic [127:0] w);
        if (is_d) begin
            d_rd[k] = rd; d_wr[k] = wr; d_ad[k] = a; d_wd[k] = w;
        end else begin
            i_rd[k] = rd; i_wr[k] = wr; i_ad[k] = a; i_wd[k] = w;
        end
    endtask

    // Memory model: wait for a grant, scramble the owner's inputs, return ready after lat cycles.
    task automatic respond(input int k, input int lat, input logic [127:0] rdata, input logic [1:0] o);
        int n = 0;
        while (own[k] == OWN_NONE && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("grant_seen", {126'd0, own[k]}, {126'd0, o});
        if (o == OWN_I) begin
            i_ad[k] = ~i_ad[k]; i_wd[k] = ~i_wd[k];
        end else begin
            d_ad[k] = ~d_ad[k]; d_wd[k] = ~d_wd[k];
        end
        repeat (lat) begin
            @(posedge clk); #1;
        end
        m_rdy[k]  = 1'b1;
        m_rdat[k] = rdata;
        @(negedge clk);
        check("ready_i", {127'd0, i_rdy[k]}, {127'd0, o == OWN_I});
        check("ready_d", {127'd0, d_rdy[k]}, {127'd0, o == OWN_D});
        check("rdata_i", i_rdat[k], rdata);
        check("rdata_d", d_rdat[k], rdata);
        check("hold_addr",  {100'd0, m_ad[k]}, {100'd0, last_exp[k].addr});
        check("hold_wdata", m_wd[k], last_exp[k].wdata);
        check("hold_read",  {127'd0, m_rd[k]}, {127'd0, last_exp[k].rd});
        @(posedge clk); #1;
        m_rdy[k] = 1'b0;
        set_req(k, o == OWN_D, 1'b0, 1'b0, 28'd0, 128'd0);
        check("done_owner", {126'd0, own[k]}, 128'd0);
        check("done_read",  {127'd0, m_rd[k]}, 128'd0);
        check("done_write", {127'd0, m_wr[k]}, 128'd0);
    endtask

    task automatic idle_ready_pulse(input int k);
        @(posedge clk); #1;
        m_rdy[k]  = 1'b1;
        m_rdat[k] = {4{32'hDEAD_BEEF}};
        @(negedge clk);
        check("idle_ready_i", {127'd0, i_rdy[k]}, 128'd0);
        check("idle_ready_d", {127'd0, d_rdy[k]}, 128'd0);
        @(posedge clk); #1;
        m_rdy[k] = 1'b0;
        check("idle_stay", {126'd0, own[k]}, 128'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_req(k, 1'b0, 1'b0, 1'b0, 28'd0, 128'd0);
            set_req(k, 1'b1, 1'b0, 1'b0, 28'd0, 128'd0);
            m_rdy[k]  = 1'b0;
            m_rdat[k] = 128'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check("rst_owner", {126'd0, own[k]}, 128'd0);
            check("rst_read",  {127'd0, m_rd[k]}, 128'd0);
            check("rst_write", {127'd0, m_wr[k]}, 128'd0);
            check("rst_addr",  {100'd0, m_ad[k]}, 128'd0);
            check("rst_wdata", m_wd[k], 128'd0);
        end

        // Round-robin: D wins first tie out of reset, then alternate.
        set_req(0, 1'b0, 1'b1, 1'b0, 28'h0000A01, {4{32'hA1A1_A1A1}});
        set_req(0, 1'b1, 1'b1, 1'b0, 28'h0000B01, {4{32'hB1B1_B1B1}});
        expect_txn(0, OWN_D, 1'b1, 1'b0, 28'h0000B01, {4{32'hB1B1_B1B1}});
        respond(0, 2, {4{32'h0101_0101}}, OWN_D);
        set_req(0, 1'b1, 1'b1, 1'b0, 28'h0000B02, {4{32'hB2B2_B2B2}});
        expect_txn(0, OWN_I, 1'b1, 1'b0, 28'h0000A01, {4{32'hA1A1_A1A1}});
        respond(0, 2, {4{32'h0202_0202}}, OWN_I);
        set_req(0, 1'b0, 1'b1, 1'b0, 28'h0000A02, {4{32'hA2A2_A2A2}});
        expect_txn(0, OWN_D, 1'b1, 1'b0, 28'h0000B02, {4{32'hB2B2_B2B2}});
        respond(0, 1, {4{32'h0303_0303}}, OWN_D);
        expect_txn(0, OWN_I, 1'b1, 1'b0, 28'h0000A02, {4{32'hA2A2_A2A2}});
        respond(0, 1, {4{32'h0404_0404}}, OWN_I);

        // Fixed priority: three back-to-back D grants, I only after D goes quiet.
        set_req(1, 1'b0, 1'b1, 1'b0, 28'h0000A11, {4{32'hC1C1_C1C1}});
        for (int j = 0; j < 3; j++) begin
            set_req(1, 1'b1, 1'b1, 1'b0, 28'h0000B10 + 28'(j), {4{32'hD0D0_D0D0}} + 128'(j));
            expect_txn(1, OWN_D, 1'b1, 1'b0, 28'h0000B10 + 28'(j), {4{32'hD0D0_D0D0}} + 128'(j));
            respond(1, 1 + j, {4{32'h1000_0000}} + 128'(j), OWN_D);
        end
        expect_txn(1, OWN_I, 1'b1, 1'b0, 28'h0000A11, {4{32'hC1C1_C1C1}});
        respond(1, 2, {4{32'h2222_2222}}, OWN_I);

        // Single D read: strobe in cycle 1, ready in cycle 4, idle in cycle 5.
        set_req(0, 1'b1, 1'b1, 1'b0, 28'h0000123, 128'd0);
        expect_txn(0, OWN_D, 1'b1, 1'b0, 28'h0000123, 128'd0);
        @(posedge clk); #1;
        check("d_read_cyc1_owner", {126'd0, own[0]}, {126'd0, OWN_D});
        check("d_read_cyc1_strobe", {127'd0, m_rd[0]}, 128'd1);
        check("d_read_cyc1_addr", {100'd0, m_ad[0]}, 128'h123);
        respond(0, 3, {4{32'h5A5A_0123}}, OWN_D);

        // Write-back then allocate read from D: read strobe at cycle k+2.
        set_req(0, 1'b1, 1'b0, 1'b1, 28'h00000A0, {8{16'h1111}});
        expect_txn(0, OWN_D, 1'b0, 1'b1, 28'h00000A0, {8{16'h1111}});
        respond(0, 2, 128'd0, OWN_D);
        set_req(0, 1'b1, 1'b1, 1'b0, 28'h00000B0, 128'd0);
        expect_txn(0, OWN_D, 1'b1, 1'b0, 28'h00000B0, 128'd0);
        @(posedge clk); #1;
        check("alloc_k2_owner", {126'd0, own[0]}, {126'd0, OWN_D});
        check("alloc_k2_read", {127'd0, m_rd[0]}, 128'd1);
        check("alloc_k2_write", {127'd0, m_wr[0]}, 128'd0);
        respond(0, 2, {4{32'h0B0B_0B0B}}, OWN_D);

        // Stray mem_ready while idle.
        idle_ready_pulse(0);
        idle_ready_pulse(1);

        // Reset during an I grant, then a late mem_ready.
        set_req(0, 1'b0, 1'b1, 1'b0, 28'h0000055, {4{32'h5555_5555}});
        expect_txn(0, OWN_I, 1'b1, 1'b0, 28'h0000055, {4{32'h5555_5555}});
        @(posedge clk); #1;
        check("pre_rst_owner", {126'd0, own[0]}, {126'd0, OWN_I});
        rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, 1'b0, 28'd0, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_owner", {126'd0, own[0]}, 128'd0);
        check("mid_rst_read",  {127'd0, m_rd[0]}, 128'd0);
        check("mid_rst_addr",  {100'd0, m_ad[0]}, 128'd0);
        idle_ready_pulse(0);

        check("queue0_empty", 128'(exp_q0.size()), 128'd0);
        check("queue1_empty", 128'(exp_q1.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one slow-memory port between the instruction cache and the data cache, so the chip needs a single external 128-bit line memory instead of one per cache.
- Sits between the two caches' memory-side interfaces and the external memory.
- Grants one whole line transaction at a time and holds the grant until the memory returns ready.
- Arbitration is fixed-priority or round-robin, chosen by parameter.

Parameters:
- ADDR_W, 28: line address width (byte address bits [31:4]).
- LINE_W, 128: line data width.
- RR_EN, 1: 1 = round-robin between I and D; 0 = D always wins a tie.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- i_mem_read  in  1  I-cache line read request.
- i_mem_write  in  1  I-cache line write request (tied 0 in the current chip, but fully supported).
- i_mem_addr  in  ADDR_W  I-cache line address.
- i_mem_wdata  in  LINE_W  I-cache write line.
- i_mem_rdata  out  LINE_W  read line returned to the I-cache.
- i_mem_ready  out  1  completion pulse to the I-cache.
- d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata, d_mem_rdata, d_mem_ready: same set for the D-cache.
- mem_read  out  1  read strobe to memory.
- mem_write  out  1  write strobe to memory.
- mem_addr  out  ADDR_W  line address to memory.
- mem_wdata  out  LINE_W  write line to memory.
- mem_rdata  in  LINE_W  read line from memory.
- mem_ready  in  1  memory completion.
- owner  out  2  current owner: 00 none, 01 I, 10 D (debug and bench use).

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-low: every register updates only on the rising edge of clk, and rst_n=0 sampled at that edge resets.
  - Reset values: state=IDLE; owner=00; mem_read=0; mem_write=0; mem_addr=0; mem_wdata=0; last_grant=I (so D wins the first tie under RR_EN=1).
- States: IDLE, GRANT_I, GRANT_D.
- IDLE:
  - Memory strobes are 0.
  - req_i = i_mem_read|i_mem_write; req_d = d_mem_read|d_mem_write.
  - At the edge:
    - Only req_i: go to GRANT_I.
    - Only req_d: go to GRANT_D.
    - Both, RR_EN=0: go to GRANT_D.
    - Both, RR_EN=1: grant the requester that is not last_grant.
    - Neither: stay in IDLE.
  - At the granting edge, register the winner's read, write, addr and wdata into the mem_* outputs, and update last_grant.
- GRANT_x:
  - mem_* outputs hold the captured values, stable for the whole transaction regardless of requester inputs.
  - Requester changes during a grant are ignored.
  - A read and write asserted together are forwarded as captured (protocol violation; the bench flags it, the RTL does not correct it).
- Return path:
  - mem_rdata is broadcast combinationally to both i_mem_rdata and d_mem_rdata.
  - x_mem_ready = mem_ready & (state==GRANT_x); the other requester's ready stays 0.
  - The ready path is combinational, same cycle as mem_ready.
- Completion: on an edge with mem_ready=1 in GRANT_x, go to IDLE and clear mem_read and mem_write. mem_addr and mem_wdata keep their last values.
- Latency:
  - Request first visible in IDLE in cycle 0 → strobe on memory in cycle 1.
  - Memory ready in cycle k → cache ready in cycle k, strobes low in cycle k+1.
  - Earliest next grant: strobe in cycle k+2, which requires the new request to be visible in IDLE during cycle k+1.
- Write-back followed by allocate from the same cache: the cache raises its read in cycle k+1 and is arbitrated normally. Under RR_EN=1 a pending I request wins that slot.
- mem_ready while in IDLE: ignored, no ready forwarded to either cache.
- Starvation: with RR_EN=1 neither requester waits more than one foreign transaction. With RR_EN=0 the I-cache can starve; this is accepted.
- Reset mid-transaction: abandon the transaction, return to reset values at that edge, and forward no ready.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding: IDLE=2'd0, GRANT_I=2'd1, GRANT_D=2'd2;
  - owner codes OWN_NONE/OWN_I/OWN_D;
  - default ADDR_W and LINE_W constants.
- One combinational sub-module, mem_arb_pick, natural to split out.
  - Inputs: req_i, req_d, last_grant, RR_EN.
  - Output: winner.
  - Lets the bench check arbitration exhaustively in isolation.

Test Plan:
- Single D read, addr 0x0000123, memory ready after 4 cycles → mem_read=1, mem_addr=0x0000123 from cycle 1; d_mem_ready pulses in cycle 4 with d_mem_rdata=mem_rdata; i_mem_ready stays 0; owner returns to 00 in cycle 5.
- I and D request together in IDLE with RR_EN=1 straight out of reset → D granted first. After D completes, with both still requesting, I is granted next. Then D, alternating.
- Same both-request stimulus with RR_EN=0 → three consecutive D transactions, with I granted only once D drops its request.
- D write-back (write, addr 0x00000A0, wdata 0x1111…) then read (addr 0x00000B0) with no I traffic → the write completes, then mem_read is seen at cycle k+2. mem_wdata is unchanged while the requester's d_mem_wdata is changed mid-grant.
- rst_n=0 for one edge while in GRANT_I, with mem_ready arriving later → owner=00 and strobes 0 after that edge, and the late mem_ready produces no cache ready.
- mem_ready pulsed in IDLE with no requests → both x_mem_ready stay 0 and the state remains IDLE.
